// File: rtl/midi_pkg.sv
// Shared types and MIDI byte-class helpers for the MIDI transmit path.
package midi_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int MIDI_BAUD = 31_250;

  function automatic logic is_status(input logic [7:0] b);
    return b[7];
  endfunction

  function automatic logic is_realtime(input logic [7:0] b);
    return b[7:3] == 5'b11111;
  endfunction

  function automatic logic is_syscommon(input logic [7:0] b);
    return b[7:3] == 5'b11110;
  endfunction

endpackage

// File: rtl/midi_tx_fifo.sv
// Small synchronous byte FIFO with fall-through read data; pointers wrap modulo DEPTH.
module midi_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk_aud,
  input  logic                     i_aud_rst_n,
  input  logic                     i_push,
  input  logic [7:0]               i_wdata,
  input  logic                     i_pop,
  output logic [7:0]               o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_err
    $error("midi_tx_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_ok, pop_ok;

  assign o_full  = count_q == (AW+1)'(DEPTH);
  assign o_empty = count_q == '0;
  assign o_count = count_q;
  assign o_rdata = mem_q[rd_ptr_q];

  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;

  always_ff @(posedge i_clk_aud or negedge i_aud_rst_n) begin
    if (!i_aud_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the empty count makes stale entries unreachable.
  always_ff @(posedge i_clk_aud) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_wdata;
  end

endmodule

// File: rtl/midi_tx.sv
// MIDI transmitter: 8N1, LSB first, idle-high, FIFO-fed back-to-back frames.
// Optional running-status suppression is built when MIDI_TX_RUNNING_STATUS_EN is defined.
module midi_tx
  import midi_pkg::*;
#(
  parameter int CLK_HZ     = 1_500_000,
  parameter int BAUD       = MIDI_BAUD,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       i_clk_aud,
  input  logic       i_aud_rst_n,
  input  logic       i_valid,
  input  logic [7:0] i_data_byte,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_busy
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  if (CLK_HZ % BAUD != 0 || CLKS_PER_BIT < 2) begin : g_baud_err
    $error("midi_tx: CLK_HZ must be an integer multiple (>= 2x) of BAUD");
  end

  tx_state_t      state_q;
  logic [CNT_W-1:0] clk_cnt_q;
  logic [2:0]     bit_cnt_q;
  logic [7:0]     shift_q;
  logic           tx_q, busy_q;

  logic [7:0]     fifo_rdata;
  logic           fifo_full, fifo_empty;
  logic [AW:0]    fifo_count;
  logic           bit_last, pop, drop, send;

  midi_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk_aud   (i_clk_aud),
    .i_aud_rst_n (i_aud_rst_n),
    .i_push      (i_valid),
    .i_wdata     (i_data_byte),
    .i_pop       (pop),
    .o_rdata     (fifo_rdata),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty),
    .o_count     (fifo_count)
  );

  assign o_ready  = !fifo_full;
  assign o_tx     = tx_q;
  assign o_busy   = busy_q;
  assign bit_last = clk_cnt_q == CNT_LAST;
  assign pop      = !fifo_empty && (state_q == IDLE || (state_q == STOP && bit_last));
  assign send     = pop && !drop;

`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic [7:0] last_status_q;

  // Channel-voice status repeated back-to-back is redundant on the wire.
  assign drop = is_status(fifo_rdata) && !is_realtime(fifo_rdata) &&
                !is_syscommon(fifo_rdata) && (fifo_rdata == last_status_q);

  always_ff @(posedge i_clk_aud or negedge i_aud_rst_n) begin
    if (!i_aud_rst_n)
      last_status_q <= 8'h00;
    else if (send && is_status(fifo_rdata) && !is_realtime(fifo_rdata))
      last_status_q <= is_syscommon(fifo_rdata) ? 8'h00 : fifo_rdata;
  end
`else
  assign drop = 1'b0;
`endif

  // IDLE: wait for byte | START: start bit | DATA: 8 bits LSB first | STOP: stop bit, chain next byte
  always_ff @(posedge i_clk_aud or negedge i_aud_rst_n) begin
    if (!i_aud_rst_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      tx_q   <= (state_q == START) ? 1'b0 : (state_q == DATA) ? shift_q[0] : 1'b1;
      busy_q <= (state_q != IDLE) || (fifo_count != '0);
      case (state_q)
        IDLE: begin
          if (send) begin
            shift_q   <= fifo_rdata;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            state_q   <= START;
          end
        end
        START: begin
          if (bit_last) begin
            clk_cnt_q <= '0;
            state_q   <= DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_last) begin
            clk_cnt_q <= '0;
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_q <= STOP;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (bit_last) begin
            clk_cnt_q <= '0;
            if (send) begin
              shift_q <= fifo_rdata;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_midi_tx.sv
// Directed self-checking bench for midi_tx with an independent line receiver model.
module tb_midi_tx;

  localparam int CPB = 48;

`ifdef MIDI_TX_RUNNING_STATUS_EN
  localparam logic [7:0] HOLD_BYTE = 8'h55;
`else
  localparam logic [7:0] HOLD_BYTE = 8'hAA;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, tx, busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q [$];
  int         rx_err = 0;
  logic [7:0] rx_byte;
  logic [7:0] rs_last = 8'h00;
  logic [7:0] rs_in [12] = '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3E, 8'h64,
                             8'hF8, 8'h90, 8'h40, 8'h64, 8'hF2, 8'h90};

  always #5 clk = ~clk;

  midi_tx dut (
    .i_clk_aud   (clk),
    .i_aud_rst_n (rst_n),
    .i_valid     (valid),
    .i_data_byte (data),
    .o_ready     (ready),
    .o_tx        (tx),
    .o_busy      (busy)
  );

  // Line receiver: samples each bit at its centre, starting from the falling edge.
  initial forever begin
    @(negedge clk);
    if (rst_n && tx === 1'b0) begin
      repeat (CPB / 2) @(negedge clk);
      if (tx !== 1'b0) rx_err++;
      for (int b = 0; b < 8; b++) begin
        repeat (CPB) @(negedge clk);
        rx_byte[b] = tx;
      end
      repeat (CPB) @(negedge clk);
      if (tx !== 1'b1) rx_err++;
      rx_q.push_back(rx_byte);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion before it");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    valid = 1'b0;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic push(input logic [7:0] b);
    int k;
    k = 0;
    valid = 1'b1;
    data  = b;
    while (!ready && k < 3000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL push_timeout: ready=%b after %0d cycles, required 1", ready, k);
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string name);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", name, busy, k);
    end
  endtask

  // Entered on the first clock of the start bit; leaves on the last stop-bit clock.
  task automatic check_frame(input logic [7:0] b, input string name);
    logic [9:0] line;
    int bad;
    line = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      bad = 0;
      for (int i = 0; i < CPB; i++) begin
        if (k != 0 || i != 0) @(negedge clk);
        if (tx !== line[k]) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s_bit%0d: %0d of 48 samples differ, required level %b", name, k, bad, line[k]);
      end
    end
  endtask

  function automatic bit rs_keep(input logic [7:0] b);
`ifdef MIDI_TX_RUNNING_STATUS_EN
    if (b >= 8'h80 && b <= 8'hEF) begin
      if (b == rs_last) return 1'b0;
      rs_last = b;
      return 1'b1;
    end
    if (b >= 8'hF0 && b <= 8'hF7) rs_last = 8'h00;
    return 1'b1;
`else
    return (b === b);
`endif
  endfunction

  task automatic test_reset();
    valid = 1'b0;
    rst_n = 1'b0;
    tick(2);
    checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL reset_tx: got %b, required 1", tx); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", ready); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    rst_n = 1'b1;
    tick(3);
    checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL post_reset_tx: got %b, required 1", tx); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL post_reset_busy: got %b, required 0", busy); end
  endtask

  task automatic test_single();
    valid = 1'b1;
    data  = 8'h90;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b, required 1", ready); end
    @(negedge clk);
    valid = 1'b0;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_lat_n: got %b, required 1", tx); end
    @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_lat_n1: got %b, required 1", tx); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_early: got %b, required 1", busy); end
    @(negedge clk);
    check_frame(8'h90, "single");
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_479: got %b, required 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_480: got %b, required 0", busy); end
    checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL single_idle_tx: got %b, required 1", tx); end
  endtask

  task automatic test_back_to_back();
    push(8'h3C);
    push(8'h64);
    push(8'h7F);
    check_frame(8'h3C, "b2b0");
    @(negedge clk);
    check_frame(8'h64, "b2b1");
    @(negedge clk);
    check_frame(8'h7F, "b2b2");
    @(negedge clk);
    checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL b2b_end_tx: got %b, required 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_end_busy: got %b, required 0", busy); end
  endtask

  task automatic test_hold();
    int acc, low, bad;
    rx_q.delete();
    acc = 0;
    low = 0;
    valid = 1'b1;
    data  = HOLD_BYTE;
    while (ready && acc < 20) begin
      acc++;
      @(negedge clk);
    end
    checks++; if (acc != 5) begin errors++; $display("FAIL hold_accepted: got %0d, required 5", acc); end
    while (!ready && low < 2000) begin
      low++;
      @(negedge clk);
    end
    checks++; if (low != 477) begin errors++; $display("FAIL hold_ready_low: got %0d cycles, required 477", low); end
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL hold_refill: ready=%b, required 0", ready); end
    valid = 1'b0;
    wait_idle(4000, "hold");
    tick(5);
    checks++; if (rx_q.size() != 6) begin errors++; $display("FAIL hold_frames: got %0d, required 6", rx_q.size()); end
    bad = 0;
    foreach (rx_q[i]) if (rx_q[i] !== HOLD_BYTE) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL hold_bytes: %0d bytes differ from required %h", bad, HOLD_BYTE); end
  endtask

  task automatic test_loopback();
    logic [7:0] exp_q [$];
    logic [7:0] b;
    apply_reset();
    rx_q.delete();
    rs_last = 8'h00;
    for (int i = 0; i < 27; i++) begin
      case (i)
        0:       b = 8'h00;
        1:       b = 8'h55;
        2:       b = 8'hFF;
        default: b = 8'($urandom_range(0, 255));
      endcase
      push(b);
      if (rs_keep(b)) exp_q.push_back(b);
    end
    wait_idle(20000, "loop");
    tick(5);
    checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL loop_count: got %0d, required %0d", rx_q.size(), exp_q.size()); end
    checks++; if (rx_err != 0) begin errors++; $display("FAIL loop_framing: got %0d framing errors, required 0", rx_err); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL loop_byte%0d: got %h, required %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int lows, busys;
    push(8'h00);
    push(8'h00);
    @(negedge clk);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL rstmid_start: got %b, required 0", tx); end
    tick(216);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL rstmid_bit3: got %b, required 0", tx); end
    rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL rstmid_tx: got %b, required 1", tx); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b, required 1", ready); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
    tick(2);
    rst_n = 1'b1;
    lows = 0;
    busys = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
    end
    checks++; if (lows != 0)  begin errors++; $display("FAIL rstmid_residual_tx: %0d low samples, required 0", lows); end
    checks++; if (busys != 0) begin errors++; $display("FAIL rstmid_residual_busy: %0d busy samples, required 0", busys); end
    rx_q.delete();
    rx_err = 0;
  endtask

  task automatic test_running_status();
    logic [7:0] exp_q [$];
`ifdef MIDI_TX_RUNNING_STATUS_EN
    exp_q = '{8'h90, 8'h3C, 8'h64, 8'h3E, 8'h64, 8'hF8, 8'h40, 8'h64, 8'hF2, 8'h90};
`else
    exp_q = '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3E, 8'h64, 8'hF8, 8'h90, 8'h40, 8'h64, 8'hF2, 8'h90};
`endif
    apply_reset();
    rx_q.delete();
    for (int i = 0; i < 12; i++) push(rs_in[i]);
    wait_idle(8000, "rs");
    tick(5);
    checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL rs_count: got %0d frames, required %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rs_byte%0d: got %h, required %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    tick(10);
    test_back_to_back();
    tick(10);
    test_hold();
    tick(10);
    test_loopback();
    tick(10);
    test_reset_mid_frame();
    test_running_status();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
